fetch_seq: RTL

- Fetch sequencer on the consuming side of the PC register.
- Takes the current `address` from the PC register and reads the instruction from a handshaked instruction memory.
- Presents the instruction to the datapath, then computes and drives `novoPC` back into the PC register.
- The PC register loads `novoPC` on every clock edge, so `fetch_seq` holds `novoPC` stable whenever the PC must not advance.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/next_pc_calc.sv | 36 +++
 rtl/fetch_seq.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
// Optional build macro used by fetch_seq: FETCH_TIMEOUT_EN.
package fetch_pkg;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    FETCH  = 2'd1,
    ISSUE  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INCR      = 32'd4;

  // Instruction field slices used by next-PC computation
  localparam int IMM_MSB = 15;  // branch immediate is instr[15:0]
  localparam int TGT_MSB = 25;  // jump target is instr[25:0]
  localparam int SEG_MSB = 31;  // jump keeps p4[31:28]
  localparam int SEG_LSB = 28;

  // Sign-extend a 16-bit branch immediate and scale it to a byte offset
  function automatic logic [31:0] sext_imm_x4(input logic [IMM_MSB:0] imm);
    return {{14{imm[IMM_MSB]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jr > jump > branch_taken > sequential.
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [31:0]      i_address,
  input  logic [TGT_MSB:0] i_instr_idx,
  input  logic             i_branch_taken,
  input  logic             i_jump,
  input  logic             i_jr,
  input  logic [31:0]      i_jr_target,
  output logic [31:0]      o_next_pc
);

  logic [31:0] w_p4;
  logic [31:0] w_branch_pc;
  logic [31:0] w_jump_pc;

  assign w_p4        = i_address + PC_INCR;
  assign w_branch_pc = w_p4 + sext_imm_x4(i_instr_idx[IMM_MSB:0]);
  assign w_jump_pc   = {w_p4[SEG_MSB:SEG_LSB], i_instr_idx, 2'b00};

  // Priority select of the next program counter
  always_comb begin
    o_next_pc = w_p4;
    if (i_jr) begin
      o_next_pc = i_jr_target;
    end else if (i_jump) begin
      o_next_pc = w_jump_pc;
    end else if (i_branch_taken) begin
      o_next_pc = w_branch_pc;
    end else begin
      o_next_pc = w_p4;
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: reads the instruction at the current PC over a
// request/ready memory handshake, issues it to the datapath and drives the
// next PC back to the PC register (which loads novoPC every cycle).
// Optional macro FETCH_TIMEOUT_EN adds a memory wait timeout that substitutes
// NOP_WORD and pulses fetch_err.
module fetch_seq
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD     = NOP_WORD_DEF,
  parameter int          TIMEOUT      = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  output logic [31:0] novoPC,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic        fetch_err
);

  fetch_state_t r_state;
  fetch_state_t w_next_state;

  logic [31:0] r_novo_pc;
  logic        r_mem_req;
  logic [31:0] r_instr;
  logic        r_instr_valid;
  logic [31:0] w_next_pc;
  logic        w_fetch_hit;
  logic        w_issue_exit;
  logic        w_timeout;

  // TIMEOUT must fit the 5-bit wait counter; out-of-range values are flagged
  // by this marker scope appearing in the elaborated hierarchy.
  if (TIMEOUT < 1 || TIMEOUT > 31) begin : g_timeout_out_of_range
  end

  assign w_fetch_hit  = (r_state == FETCH) && r_mem_req && mem_ready;
  assign w_issue_exit = (r_state == ISSUE) && !stall;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [4:0] TIMEOUT_LAST = 5'(TIMEOUT - 1);

  logic [4:0] r_wait_cnt;
  logic       r_fetch_err;

  assign w_timeout = (r_state == FETCH) && !mem_ready && (r_wait_cnt == TIMEOUT_LAST);

  // Count FETCH cycles spent waiting; cleared whenever not fetching
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= 5'd0;
    end else if (r_state != FETCH) begin
      r_wait_cnt <= 5'd0;
    end else if (!mem_ready) begin
      r_wait_cnt <= r_wait_cnt + 5'd1;
    end
  end

  // One-cycle error pulse coinciding with the first ISSUE cycle after a timeout
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fetch_err <= 1'b0;
    end else begin
      r_fetch_err <= w_timeout;
    end
  end

  assign fetch_err = r_fetch_err;
`else
  assign w_timeout = 1'b0;
  assign fetch_err = 1'b0;
`endif

  next_pc_calc u_next_pc_calc (
    .i_address      (address),
    .i_instr_idx    (r_instr[TGT_MSB:0]),
    .i_branch_taken (branch_taken),
    .i_jump         (jump),
    .i_jr           (jr),
    .i_jr_target    (jr_target),
    .o_next_pc      (w_next_pc)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= SETTLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      SETTLE: begin
        w_next_state = FETCH;
      end
      FETCH: begin
        if (w_fetch_hit || w_timeout) begin
          w_next_state = ISSUE;
        end else begin
          w_next_state = FETCH;
        end
      end
      ISSUE: begin
        if (w_issue_exit) begin
          w_next_state = SETTLE;
        end else begin
          w_next_state = ISSUE;
        end
      end
      default: begin
        w_next_state = SETTLE;
      end
    endcase
  end

  // Registered handshake and issue flags, decoded from the upcoming state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mem_req     <= 1'b0;
      r_instr_valid <= 1'b0;
    end else begin
      r_mem_req     <= (w_next_state == FETCH);
      r_instr_valid <= (w_next_state == ISSUE);
    end
  end

  // Instruction latch: memory word on a hit, NOP on timeout, else hold
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_instr <= NOP_WORD;
    end else if (w_fetch_hit) begin
      r_instr <= mem_rdata;
    end else if (w_timeout) begin
      r_instr <= NOP_WORD;
    end
  end

  // Next PC only moves when the issued instruction retires; otherwise it
  // equals address so the PC register holds
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_novo_pc <= RESET_VECTOR;
    end else if (w_issue_exit) begin
      r_novo_pc <= w_next_pc;
    end
  end

  assign novoPC      = r_novo_pc;
  assign mem_req     = r_mem_req;
  assign mem_addr    = address;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;

endmodule
